// File: rtl/axi_lite_regbank_if.sv
// axi_lite_regbank_if: five-channel AXI-lite subset without strobes, prot or IDs.
// The master modport drives requests; the slave modport drives readies and responses.
interface axi_lite_regbank_if;
  logic        s_arvalid_i;
  logic        s_aready_o;
  logic [31:0] s_araddr_i;
  logic        s_rvalid_o;
  logic        s_rready_i;
  logic [31:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        s_awvalid_i;
  logic        s_awready_o;
  logic [31:0] s_awaddr_i;
  logic        s_wvalid_i;
  logic        s_wready_o;
  logic [31:0] s_wdata_i;
  logic        s_bvalid_o;
  logic        s_bready_i;
  logic [1:0]  s_bresp_o;

  modport master (
    output s_arvalid_i, s_araddr_i, s_rready_i,
    output s_awvalid_i, s_awaddr_i,
    output s_wvalid_i, s_wdata_i, s_bready_i,
    input  s_aready_o, s_rvalid_o, s_rdata_o, s_rresp_o,
    input  s_awready_o, s_wready_o,
    input  s_bvalid_o, s_bresp_o
  );

  modport slave (
    input  s_arvalid_i, s_araddr_i, s_rready_i,
    input  s_awvalid_i, s_awaddr_i,
    input  s_wvalid_i, s_wdata_i, s_bready_i,
    output s_aready_o, s_rvalid_o, s_rdata_o, s_rresp_o,
    output s_awready_o, s_wready_o,
    output s_bvalid_o, s_bresp_o
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI-lite responder with NUM_REGS 32-bit R/W registers.
// Define AXI_LITE_REGBANK_HW_IF_EN to export hw_regs_o and hw_wr_pulse_o.
module axi_lite_regbank #(
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef AXI_LITE_REGBANK_HW_IF_EN
  output logic [32*NUM_REGS-1:0] hw_regs_o,
  output logic [NUM_REGS-1:0]    hw_wr_pulse_o,
`endif
  axi_lite_regbank_if.slave s
);
  localparam int unsigned IW =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } rstate_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_COMMIT,
    W_RESP
  } wstate_e;

  rstate_e     rstate_q, rstate_d;
  wstate_e     wstate_q, wstate_d;
  logic        init_q, init_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [31:0]   ar_off;
  logic [31:0]   aw_off;
  logic          ar_hit;
  logic          aw_hit;
  logic [IW-1:0] ar_idx;
  logic [IW-1:0] aw_idx;
  logic          wr_en;
  logic          unused_lsb;

  // Byte lanes inside a word are ignored; only word index matters.
  assign ar_off = s.s_araddr_i - BASE_ADDR;
  assign aw_off = awaddr_q - BASE_ADDR;
  assign ar_idx = ar_off[IW+1:2];
  assign aw_idx = aw_off[IW+1:2];
  assign unused_lsb = ^{ar_off[1:0], aw_off[1:0]};

  assign ar_hit = (s.s_araddr_i >= BASE_ADDR) &&
                  ({2'b00, ar_off[31:2]} < 32'(NUM_REGS));
  assign aw_hit = (awaddr_q >= BASE_ADDR) &&
                  ({2'b00, aw_off[31:2]} < 32'(NUM_REGS));

  assign init_d = 1'b0;

  assign s.s_rdata_o = rdata_q;
  assign s.s_rresp_o = rresp_q;
  assign s.s_bresp_o = bresp_q;

  always_comb begin
    rstate_d     = rstate_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    s.s_aready_o = 1'b0;
    s.s_rvalid_o = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        s.s_aready_o = !init_q;
        if (!init_q && s.s_arvalid_i) begin
          rstate_d = R_VALID;
          rdata_d  = ar_hit ? regs_q[ar_idx] : 32'h0;
          rresp_d  = ar_hit ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_VALID: begin
        s.s_rvalid_o = 1'b1;
        if (s.s_rready_i) begin
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d      = wstate_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    bresp_d       = bresp_q;
    wr_en         = 1'b0;
    s.s_awready_o = 1'b0;
    s.s_wready_o  = 1'b0;
    s.s_bvalid_o  = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        s.s_awready_o = !init_q;
        s.s_wready_o  = !init_q;
        if (!init_q) begin
          if (s.s_awvalid_i) begin
            awaddr_d = s.s_awaddr_i;
          end
          if (s.s_wvalid_i) begin
            wdata_d = s.s_wdata_i;
          end
          unique case (1'b1)
            s.s_awvalid_i && s.s_wvalid_i:
              wstate_d = W_COMMIT;
            s.s_awvalid_i && !s.s_wvalid_i:
              wstate_d = W_WAIT_DATA;
            !s.s_awvalid_i && s.s_wvalid_i:
              wstate_d = W_WAIT_ADDR;
            default: wstate_d = W_IDLE;
          endcase
        end
      end
      W_WAIT_DATA: begin
        s.s_wready_o = 1'b1;
        if (s.s_wvalid_i) begin
          wdata_d  = s.s_wdata_i;
          wstate_d = W_COMMIT;
        end
      end
      W_WAIT_ADDR: begin
        s.s_awready_o = 1'b1;
        if (s.s_awvalid_i) begin
          awaddr_d = s.s_awaddr_i;
          wstate_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        wr_en    = aw_hit;
        bresp_d  = aw_hit ? RESP_OKAY : RESP_SLVERR;
        wstate_d = W_RESP;
      end
      W_RESP: begin
        s.s_bvalid_o = 1'b1;
        if (s.s_bready_i) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // A read sampling on the commit edge sees the old value.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[aw_idx] = wdata_q;
    end
  end

`ifdef AXI_LITE_REGBANK_HW_IF_EN
  always_comb begin
    hw_regs_o     = '0;
    hw_wr_pulse_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      hw_regs_o[32*i +: 32] = regs_q[i];
    end
    if (wr_en) begin
      hw_wr_pulse_o[aw_idx] = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      init_q   <= 1'b1;
      rstate_q <= R_IDLE;
      wstate_q <= W_IDLE;
      regs_q   <= '{default: '0};
      rdata_q  <= '0;
      rresp_q  <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      bresp_q  <= '0;
    end else begin
      init_q   <= init_d;
      rstate_q <= rstate_d;
      wstate_q <= wstate_d;
      regs_q   <= regs_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      bresp_q  <= bresp_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: randomized self-checking bench for axi_lite_regbank.
// Expected values come from an array model of the register map.
module tb_axi_lite_regbank;
  localparam int unsigned NR   = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [31:0] model [NR];

  axi_lite_regbank_if bus();

`ifdef AXI_LITE_REGBANK_HW_IF_EN
  logic [32*NR-1:0] hw_regs;
  logic [NR-1:0]    hw_pulse;
`endif

  axi_lite_regbank #(
    .NUM_REGS (NR),
    .BASE_ADDR(BASE)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
`ifdef AXI_LITE_REGBANK_HW_IF_EN
    .hw_regs_o    (hw_regs),
    .hw_wr_pulse_o(hw_pulse),
`endif
    .s            (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE) return 1'b0;
    off = a - BASE;
    return (off / 4) < NR;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 7)
      return BASE + 4 * $urandom_range(0, NR - 1) + $urandom_range(0, 3);
    else if (k < 9)
      return BASE + 4 * NR + $urandom_range(0, 255);
    else
      return BASE - $urandom_range(1, 64);
  endfunction

  task automatic idle_inputs();
    bus.s_arvalid_i = 1'b0;
    bus.s_araddr_i  = '0;
    bus.s_rready_i  = 1'b0;
    bus.s_awvalid_i = 1'b0;
    bus.s_awaddr_i  = '0;
    bus.s_wvalid_i  = 1'b0;
    bus.s_wdata_i   = '0;
    bus.s_bready_i  = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic do_read(input logic [31:0] a, input int r_dly,
                         output logic [31:0] d, output logic [1:0] r,
                         output int lat);
    int c;
    bit hs;
    c = 0;
    hs = 1'b0;
    bus.s_araddr_i  = a;
    bus.s_arvalid_i = 1'b1;
    bus.s_rready_i  = 1'b0;
    while (!hs && c < 100) begin
      hs = bus.s_aready_o;
      @(negedge clk);
      c++;
    end
    bus.s_arvalid_i = 1'b0;
    if (!hs) begin
      n_err++;
      $display("FAIL read_ar_timeout: addr %h no aready in 100 cycles", a);
    end
    lat = 1;
    while (!bus.s_rvalid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (r_dly) @(negedge clk);
    d = bus.s_rdata_o;
    r = bus.s_rresp_o;
    bus.s_rready_i = 1'b1;
    @(negedge clk);
    bus.s_rready_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input int aw_dly, input int w_dly,
                          input int b_dly, output logic [1:0] r,
                          output int lat);
    int c;
    bit aw_done, w_done, aw_hs, w_hs;
    c = 0;
    aw_done = 1'b0;
    w_done = 1'b0;
    bus.s_awaddr_i = a;
    bus.s_wdata_i  = d;
    bus.s_bready_i = 1'b0;
    while (!(aw_done && w_done) && c < 100) begin
      bus.s_awvalid_i = !aw_done && (c >= aw_dly);
      bus.s_wvalid_i  = !w_done && (c >= w_dly);
      aw_hs = bus.s_awvalid_i && bus.s_awready_o;
      w_hs  = bus.s_wvalid_i && bus.s_wready_o;
      @(negedge clk);
      c++;
      if (aw_hs) aw_done = 1'b1;
      if (w_hs) w_done = 1'b1;
    end
    bus.s_awvalid_i = 1'b0;
    bus.s_wvalid_i  = 1'b0;
    if (!(aw_done && w_done)) begin
      n_err++;
      $display("FAIL write_hs_timeout: addr %h handshakes incomplete", a);
    end
    lat = 1;
    while (!bus.s_bvalid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (b_dly) @(negedge clk);
    r = bus.s_bresp_o;
    bus.s_bready_i = 1'b1;
    @(negedge clk);
    bus.s_bready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.s_aready_o, bus.s_rvalid_o, bus.s_rdata_o, bus.s_rresp_o,
         bus.s_awready_o, bus.s_wready_o, bus.s_bvalid_o,
         bus.s_bresp_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ar%b rv%b rd%h rr%b aw%b w%b bv%b br%b, want all 0",
               bus.s_aready_o, bus.s_rvalid_o, bus.s_rdata_o, bus.s_rresp_o,
               bus.s_awready_o, bus.s_wready_o, bus.s_bvalid_o, bus.s_bresp_o);
    end
`ifdef AXI_LITE_REGBANK_HW_IF_EN
    n_vec++;
    if ({hw_regs, hw_pulse} !== '0) begin
      n_err++;
      $display("FAIL reset_hw: got regs %h pulse %b, want 0", hw_regs, hw_pulse);
    end
`endif
    rst_n = 1'b1;
    #1;
    n_vec++;
    if ({bus.s_aready_o, bus.s_awready_o, bus.s_wready_o} !== 3'b000) begin
      n_err++;
      $display("FAIL init_ready_low: got %b want 000",
               {bus.s_aready_o, bus.s_awready_o, bus.s_wready_o});
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.s_aready_o, bus.s_awready_o, bus.s_wready_o} !== 3'b111) begin
      n_err++;
      $display("FAIL ready_after_init: got %b want 111",
               {bus.s_aready_o, bus.s_awready_o, bus.s_wready_o});
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int i = 0; i < NR; i++) begin
      do_read(BASE + 4 * i, 0, d, r, lat);
      n_vec++;
      if ({d, r} !== {32'h0, 2'b00}) begin
        n_err++;
        $display("FAIL reset_read reg%0d: got %h/%b want 00000000/00", i, d, r);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    do_write(BASE + 32'h8, 32'hCAFE_F00D, 0, 0, 0, r, lat);
    model[2] = 32'hCAFE_F00D;
    n_vec++;
    if (r !== 2'b00 || lat !== 2) begin
      n_err++;
      $display("FAIL wr_basic: got bresp %b lat %0d, want 00 lat 2", r, lat);
    end
    do_read(BASE + 32'h8, 0, d, r, lat);
    n_vec++;
    if (d !== 32'hCAFE_F00D || r !== 2'b00 || lat !== 1) begin
      n_err++;
      $display("FAIL rd_basic: got %h/%b lat %0d, want cafef00d/00 lat 1", d, r, lat);
    end
  endtask

  task automatic test_split_order();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bus.s_wdata_i  = 32'h1234_5678;
    bus.s_wvalid_i = 1'b1;
    @(negedge clk);
    bus.s_wvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({bus.s_awready_o, bus.s_wready_o} !== 2'b10) begin
        n_err++;
        $display("FAIL split_wait c%0d: got aw/w ready %b want 10", k,
                 {bus.s_awready_o, bus.s_wready_o});
      end
      if (k == 2) begin
        bus.s_awaddr_i  = BASE + 32'h4;
        bus.s_awvalid_i = 1'b1;
      end
      @(negedge clk);
    end
    bus.s_awvalid_i = 1'b0;
    model[1] = 32'h1234_5678;
    n_vec++;
    if (bus.s_bvalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL split_commit: got bvalid %b want 0", bus.s_bvalid_o);
    end
    @(negedge clk);
    n_vec++;
    if (bus.s_bvalid_o !== 1'b1 || bus.s_bresp_o !== 2'b00) begin
      n_err++;
      $display("FAIL split_bresp: got bvalid %b bresp %b want 1/00",
               bus.s_bvalid_o, bus.s_bresp_o);
    end
    bus.s_bready_i = 1'b1;
    @(negedge clk);
    bus.s_bready_i = 1'b0;
    for (int i = 0; i < NR; i++) begin
      do_read(BASE + 4 * i, 0, d, r, lat);
      n_vec++;
      if (d !== model[i] || r !== 2'b00) begin
        n_err++;
        $display("FAIL split_readback reg%0d: got %h/%b want %h/00", i, d, r, model[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    do_write(BASE + 32'h20, 32'hFFFF_FFFF, 0, 0, 0, r, lat);
    n_vec++;
    if (r !== 2'b10) begin
      n_err++;
      $display("FAIL oor_wr_hi: got bresp %b want 10", r);
    end
    do_write(BASE - 32'h4, 32'hFFFF_FFFF, 1, 0, 0, r, lat);
    n_vec++;
    if (r !== 2'b10) begin
      n_err++;
      $display("FAIL oor_wr_lo: got bresp %b want 10", r);
    end
    for (int i = 0; i < NR; i++) begin
      do_read(BASE + 4 * i, 0, d, r, lat);
      n_vec++;
      if (d !== model[i] || r !== 2'b00) begin
        n_err++;
        $display("FAIL oor_unchanged reg%0d: got %h/%b want %h/00", i, d, r, model[i]);
      end
    end
    do_read(BASE + 32'h20, 0, d, r, lat);
    n_vec++;
    if (d !== 32'h0 || r !== 2'b10) begin
      n_err++;
      $display("FAIL oor_rd: got %h/%b want 00000000/10", d, r);
    end
  endtask

  task automatic test_backpressure();
    bus.s_araddr_i  = BASE + 32'h8;
    bus.s_arvalid_i = 1'b1;
    @(negedge clk);
    bus.s_arvalid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (bus.s_rvalid_o !== 1'b1 || bus.s_rdata_o !== model[2] ||
          bus.s_rresp_o !== 2'b00 || bus.s_aready_o !== 1'b0) begin
        n_err++;
        $display("FAIL rd_stall c%0d: got rv%b %h/%b ar%b want 1 %h/00 ar0", k,
                 bus.s_rvalid_o, bus.s_rdata_o, bus.s_rresp_o, bus.s_aready_o,
                 model[2]);
      end
      @(negedge clk);
    end
    bus.s_rready_i = 1'b1;
    @(negedge clk);
    bus.s_rready_i = 1'b0;
    n_vec++;
    if (bus.s_rvalid_o !== 1'b0 || bus.s_aready_o !== 1'b1) begin
      n_err++;
      $display("FAIL rd_release: got rv%b ar%b want rv0 ar1",
               bus.s_rvalid_o, bus.s_aready_o);
    end
    bus.s_awaddr_i  = BASE + 32'h1C;
    bus.s_wdata_i   = 32'h0BAD_BEEF;
    bus.s_awvalid_i = 1'b1;
    bus.s_wvalid_i  = 1'b1;
    @(negedge clk);
    bus.s_awvalid_i = 1'b0;
    bus.s_wvalid_i  = 1'b0;
    model[7] = 32'h0BAD_BEEF;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (bus.s_bvalid_o !== 1'b1 || bus.s_bresp_o !== 2'b00 ||
          bus.s_awready_o !== 1'b0 || bus.s_wready_o !== 1'b0) begin
        n_err++;
        $display("FAIL wr_stall c%0d: got bv%b br%b aw%b w%b want 1 00 0 0", k,
                 bus.s_bvalid_o, bus.s_bresp_o, bus.s_awready_o, bus.s_wready_o);
      end
      @(negedge clk);
    end
    bus.s_bready_i = 1'b1;
    @(negedge clk);
    bus.s_bready_i = 1'b0;
    n_vec++;
    if (bus.s_bvalid_o !== 1'b0 || bus.s_awready_o !== 1'b1) begin
      n_err++;
      $display("FAIL wr_release: got bv%b aw%b want bv0 aw1",
               bus.s_bvalid_o, bus.s_awready_o);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    do_write(BASE + 32'h4, 32'hA, 0, 0, 0, r, lat);
    model[1] = 32'hA;
    bus.s_awaddr_i  = BASE + 32'h4;
    bus.s_wdata_i   = 32'hB;
    bus.s_awvalid_i = 1'b1;
    bus.s_wvalid_i  = 1'b1;
    bus.s_rready_i  = 1'b1;
    bus.s_bready_i  = 1'b1;
    @(negedge clk);
    bus.s_awvalid_i = 1'b0;
    bus.s_wvalid_i  = 1'b0;
    bus.s_araddr_i  = BASE + 32'h4;
    bus.s_arvalid_i = 1'b1;
`ifdef AXI_LITE_REGBANK_HW_IF_EN
    n_vec++;
    if (hw_pulse !== 8'b0000_0010) begin
      n_err++;
      $display("FAIL coll_pulse_on: got %b want 00000010", hw_pulse);
    end
`endif
    @(negedge clk);
    bus.s_arvalid_i = 1'b0;
    n_vec++;
    if (bus.s_rvalid_o !== 1'b1 || bus.s_rdata_o !== 32'hA ||
        bus.s_rresp_o !== 2'b00) begin
      n_err++;
      $display("FAIL coll_old: got rv%b %h/%b want 1 0000000a/00",
               bus.s_rvalid_o, bus.s_rdata_o, bus.s_rresp_o);
    end
`ifdef AXI_LITE_REGBANK_HW_IF_EN
    n_vec++;
    if (hw_pulse !== 8'b0 || hw_regs[63:32] !== 32'hB) begin
      n_err++;
      $display("FAIL coll_pulse_off: got pulse %b reg1 %h want 0/0000000b",
               hw_pulse, hw_regs[63:32]);
    end
`endif
    @(negedge clk);
    bus.s_rready_i = 1'b0;
    bus.s_bready_i = 1'b0;
    model[1] = 32'hB;
    do_read(BASE + 32'h4, 0, d, r, lat);
    n_vec++;
    if (d !== 32'hB || r !== 2'b00) begin
      n_err++;
      $display("FAIL coll_new: got %h/%b want 0000000b/00", d, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bus.s_awaddr_i  = BASE + 32'h10;
    bus.s_wdata_i   = 32'h5555_AAAA;
    bus.s_awvalid_i = 1'b1;
    bus.s_wvalid_i  = 1'b1;
    bus.s_bready_i  = 1'b1;
    @(negedge clk);
    idle_inputs();
    bus.s_bready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    n_vec++;
    if (bus.s_bvalid_o !== 1'b0 || bus.s_awready_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got bv%b aw%b want 0 0",
               bus.s_bvalid_o, bus.s_awready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (bus.s_bvalid_o !== 1'b0) begin
        n_err++;
        $display("FAIL mid_reset_noresp: got bvalid %b want 0", bus.s_bvalid_o);
      end
    end
    bus.s_bready_i = 1'b0;
    do_read(BASE + 32'h8, 0, d, r, lat);
    n_vec++;
    if (d !== 32'h0 || r !== 2'b00) begin
      n_err++;
      $display("FAIL mid_reset_clear: got %h/%b want 00000000/00", d, r);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, got;
    logic [1:0]  r, er;
    int          lat;
    for (int n = 0; n < 80; n++) begin
      a = rand_addr();
      er = in_rng(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), r, lat);
        if (in_rng(a)) model[idx_of(a)] = d;
        n_vec++;
        if (r !== er || lat !== 2) begin
          n_err++;
          $display("FAIL rnd_wr %0d addr %h: got %b lat %0d want %b lat 2",
                   n, a, r, lat, er);
        end
      end else begin
        do_read(a, $urandom_range(0, 3), got, r, lat);
        d = in_rng(a) ? model[idx_of(a)] : 32'h0;
        n_vec++;
        if (got !== d || r !== er || lat !== 1) begin
          n_err++;
          $display("FAIL rnd_rd %0d addr %h: got %h/%b lat %0d want %h/%b lat 1",
                   n, a, got, r, lat, d, er);
        end
      end
`ifdef AXI_LITE_REGBANK_HW_IF_EN
      for (int i = 0; i < NR; i++) begin
        n_vec++;
        if (hw_regs[32*i +: 32] !== model[i]) begin
          n_err++;
          $display("FAIL rnd_hw reg%0d: got %h want %h", i,
                   hw_regs[32*i +: 32], model[i]);
        end
      end
`endif
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_split_order();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
